// File: rtl/alk_pkg.sv
// Shared ALK Q-shifter types: sequencer states, DQ bit positions, MUX shift-select masks.
package alk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alk_state_e;

    localparam int DQ_DIR = 0;
    localparam int DQ_SRC = 1;

    // A MUX code selects a shift when every SET bit is 1 and every CLR bit is 0 (1, 3, 9, B).
    localparam logic [3:0] MUX_SHF_SET = 4'b0001;
    localparam logic [3:0] MUX_SHF_CLR = 4'b0100;

    function automatic logic mux_is_shift(input logic [3:0] mux);
        return ((mux & MUX_SHF_SET) == MUX_SHF_SET) && ((mux & MUX_SHF_CLR) == 4'b0000);
    endfunction

endpackage

// File: rtl/alkqdec.sv
// Purpose: decode MUX field plus DQ direction bit into no-shift / shift-left / shift-right.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs track inputs continuously.
module alkqdec
    import alk_pkg::*;
(
    input  logic [3:0] mux_h,
    input  logic       dq_dir_h,
    output logic       q_noshf_h,
    output logic       q_shl_l,
    output logic       q_shr_l
);

    logic shf;

    always_comb begin
        shf       = mux_is_shift(mux_h);
        q_noshf_h = ~shf;
        q_shl_l   = ~(shf & ~dq_dir_h);
        q_shr_l   = ~(shf & dq_dir_h);
    end

endmodule

// File: rtl/alkqshf.sv
// Purpose: Q register with decoded single shifts and counted shift sequences (start/done); ALK_QROT_EN adds rotate.
// Latency: load/shift visible 1 cycle after sampling; N-step sequence shifts at edges 1..N, done_h after edge N+1.
// Backpressure: start_h and q_load_h are ignored while RUN or DONE; busy_h marks the RUN window.
module alkqshf
    import alk_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_h,
    input  logic             reset_h,
    input  logic [3:0]       mux_h,
    input  logic [1:0]       dq_h,
    input  logic             q_load_h,
    input  logic [WIDTH-1:0] q_d_h,
    input  logic             sin_l_h,
    input  logic             sin_r_h,
    input  logic             start_h,
    input  logic [CNT_W-1:0] count_h,
    output logic [WIDTH-1:0] q_h,
    output logic             sout_h,
    output logic             q_noshf_h,
    output logic             q_shl_l,
    output logic             q_shr_l,
    output logic             busy_h,
    output logic             done_h
);

    alk_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] qreg_q, qreg_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef ALK_QROT_EN
    logic             src_q, src_d;
`else
    logic             unused_dq_src;
    assign unused_dq_src = dq_h[DQ_SRC];
`endif

    logic             rot_sel;
    logic             shl_in;
    logic             shr_in;
    logic [WIDTH-1:0] q_left;
    logic [WIDTH-1:0] q_right;
    logic             dir_eff;

    alkqdec u_dec (
        .mux_h     (mux_h),
        .dq_dir_h  (dq_h[DQ_DIR]),
        .q_noshf_h (q_noshf_h),
        .q_shl_l   (q_shl_l),
        .q_shr_l   (q_shr_l)
    );

    always_comb begin
`ifdef ALK_QROT_EN
        rot_sel = (state_q == ST_RUN) ? src_q : dq_h[DQ_SRC];
`else
        rot_sel = 1'b0;
`endif
        shl_in  = rot_sel ? qreg_q[WIDTH-1] : sin_l_h;
        shr_in  = rot_sel ? qreg_q[0] : sin_r_h;
        q_left  = {qreg_q[WIDTH-2:0], shl_in};
        q_right = {shr_in, qreg_q[WIDTH-1:1]};
        dir_eff = (state_q == ST_RUN) ? dir_q : dq_h[DQ_DIR];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        qreg_d  = qreg_q;
        dir_d   = dir_q;
`ifdef ALK_QROT_EN
        src_d   = src_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (q_load_h) begin
                    qreg_d = q_d_h;
                end else if (!q_shl_l) begin
                    qreg_d = q_left;
                end else if (!q_shr_l) begin
                    qreg_d = q_right;
                end
                if (start_h) begin
                    cnt_d   = count_h;
                    dir_d   = dq_h[DQ_DIR];
`ifdef ALK_QROT_EN
                    src_d   = dq_h[DQ_SRC];
`endif
                    state_d = (count_h == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                qreg_d = dir_q ? q_right : q_left;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        // The pulse trails the DONE state by a cycle, so it lands on the first cycle a new start is accepted.
        done_d = (state_q == ST_DONE);
    end

    always_ff @(posedge clk_h) begin
        if (reset_h) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            qreg_q  <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ALK_QROT_EN
            src_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qreg_q  <= qreg_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef ALK_QROT_EN
            src_q   <= src_d;
`endif
        end
    end

    assign q_h    = qreg_q;
    assign sout_h = dir_eff ? qreg_q[0] : qreg_q[WIDTH-1];
    assign busy_h = busy_q;
    assign done_h = done_q;

endmodule
